whack_input_conditioner: RTL and testbench
==========================================

WHACK_INPUT_CONDITIONER -- requirements
Module: whack_input_conditioner

Interface
REQ-001 Parameter NUM_SW, default 16, number of player switches (fixed at 16 in this design).
REQ-002 Parameter TICK_CYCLES, default 1_000_000, clk cycles per debounce sample (10 ms at 100 MHz); legal range 2 to 2^24-1.
REQ-003 clk  input  1  100 MHz system clock; only clock in the block.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 sw  input  16  raw slide-switch levels, asynchronous to clk.
REQ-006 mole_mask  input  16  LEDs currently lit by the game, one bit per switch.
REQ-007 hit_ready  input  1  game accepts the presented event.
REQ-008 hit_valid  output  1  a whack event is presented.
REQ-009 hit_idx  output  4  index of the presented switch.
REQ-010 hit_is_mole  output  1  mole_mask bit of hit_idx at the time the event was detected.
REQ-011 drop_err  output  1  sticky flag: at least one event was lost.

Function
REQ-012 Each sw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 A prescaler SHALL emit a 1-cycle tick every TICK_CYCLES clk cycles, counting from reset release.
REQ-014 On each tick, each switch SHALL record its synchronized level as a sample, keeping the previous sample.
REQ-015 A switch's stable level SHALL update on a tick only when the new sample equals the previous sample and differs from the stable level.
REQ-016 Any stable-level change, 0->1 or 1->0, SHALL be one whack event for that switch.
REQ-017 On a whack event, pending[i] SHALL be set and hitmask[i] SHALL capture mole_mask[i] in the same cycle.
REQ-018 hit_valid SHALL equal OR of pending; hit_idx SHALL be the lowest set pending index; hit_is_mole SHALL be hitmask[hit_idx].
REQ-019 A transfer SHALL occur on a clk edge with hit_valid=1 and hit_ready=1; pending[hit_idx] then clears.
REQ-020 While hit_valid=1 and hit_ready=0, hit_idx and hit_is_mole SHALL stay stable unless a lower-index event becomes pending; the presented index may then change.
REQ-021 An event on switch i while pending[i]=1 and not transferring in that cycle SHALL be dropped: hitmask[i] is unchanged and drop_err is set.
REQ-022 A transfer of index i and a new event on i in the same cycle SHALL leave pending[i]=1 with hitmask[i] taking the new capture, and no drop.
REQ-023 drop_err SHALL clear only on reset.
REQ-024 Latency SHALL be 2 sync cycles plus at most 2 ticks plus 1 cycle from a sw change to hit_valid.
REQ-025 Glitches shorter than one tick period SHALL produce no event.

Reset
REQ-026 While reset=0: hit_valid=0, hit_idx=0, hit_is_mole=0, drop_err=0; pending, hitmask and prescaler are 0.
REQ-027 While reset=0, the synchronizers, samples and stable levels SHALL load the current raw sw, so switch positions at reset release produce no events.
REQ-028 Reset asserted mid-handshake SHALL discard all pending events immediately, without waiting for a clk edge.

Structure
REQ-029 Shared package SHALL hold NUM_SW_C=16, IDX_W_C=4 and DEFAULT_TICK_CYCLES_C=1_000_000.
REQ-030 The prescaler SHALL be one sub-module, debounce_tick_gen, with parameter TICK_CYCLES and ports clk, reset and tick.
REQ-031 The priority encoder SHALL be combinational inside this block.

Verification (TICK_CYCLES=4 for all scenarios)
REQ-032 sw=0x0000 at reset release, held 40 cycles -> hit_valid stays 0; drop_err=0.
REQ-033 mole_mask=0x0020; sw[5] 0->1 held; hit_ready=1 -> one hit_valid pulse with hit_idx=5, hit_is_mole=1, within 2+8+1 cycles.
REQ-034 sw[3] pulsed high for 2 cycles -> no event.
REQ-035 sw[9] and sw[2] toggle at the same time; hit_ready=0 for 20 cycles, then 1 -> hit_idx=2 is held until the first accept, then hit_idx=9, then hit_valid=0.
REQ-036 sw[7] toggled, stable, then toggled back with hit_ready=0 throughout -> drop_err=1; exactly one event is delivered on release.
REQ-037 reset pulsed low while hit_valid=1 -> hit_valid=0 immediately; no stale event appears after release.

Source files
------------

// File: rtl/whack_input_conditioner_pkg.sv
// rtl/whack_input_conditioner_pkg.sv - shared constants for the whack input conditioner
package whack_input_conditioner_pkg;

  localparam int NUM_SW_C              = 16;
  localparam int IDX_W_C               = 4;
  localparam int DEFAULT_TICK_CYCLES_C = 1_000_000;
  localparam int TICK_CNT_W_C          = 24;

endpackage

// File: rtl/whack_input_conditioner_debounce_tick_gen.sv
// rtl/whack_input_conditioner_debounce_tick_gen.sv - debounce sample prescaler, one-cycle tick every TICK_CYCLES clocks
module debounce_tick_gen
  import whack_input_conditioner_pkg::*;
#(
  parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES_C
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [TICK_CNT_W_C-1:0] LAST_C = TICK_CNT_W_C'(TICK_CYCLES - 1);
  localparam logic [TICK_CNT_W_C-1:0] ONE_C  = TICK_CNT_W_C'(1);

  logic [TICK_CNT_W_C-1:0] cnt_q;
  logic [TICK_CNT_W_C-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST_C);
    cnt_d = tick ? '0 : cnt_q + ONE_C;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/whack_input_conditioner.sv
// rtl/whack_input_conditioner.sv - synchronize, debounce and queue switch whack events for the game
module whack_input_conditioner
  import whack_input_conditioner_pkg::*;
#(
  parameter int NUM_SW      = NUM_SW_C,
  parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES_C
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SW-1:0]  sw,
  input  logic [NUM_SW-1:0]  mole_mask,
  input  logic               hit_ready,
  output logic               hit_valid,
  output logic [IDX_W_C-1:0] hit_idx,
  output logic               hit_is_mole,
  output logic               drop_err
);

  logic [NUM_SW-1:0] sync1_q;
  logic [NUM_SW-1:0] sync2_q;
  logic [NUM_SW-1:0] sample_q;
  logic [NUM_SW-1:0] sample_d;
  logic [NUM_SW-1:0] stable_q;
  logic [NUM_SW-1:0] stable_d;
  logic [NUM_SW-1:0] whack;
  logic [NUM_SW-1:0] pending_q;
  logic [NUM_SW-1:0] pending_d;
  logic [NUM_SW-1:0] hitmask_q;
  logic [NUM_SW-1:0] hitmask_d;
  logic              drop_err_q;
  logic              drop_err_d;
  logic              tick;
  logic              xfer;

  debounce_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Held in reset these track the raw switches, so positions at release are not events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= sw;
      sync2_q  <= sw;
      sample_q <= sw;
      stable_q <= sw;
    end else begin
      sync1_q  <= sw;
      sync2_q  <= sync1_q;
      sample_q <= sample_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    sample_d = sample_q;
    stable_d = stable_q;
    whack    = '0;
    if (tick) begin
      sample_d = sync2_q;
      whack    = ~(sync2_q ^ sample_q) & (sync2_q ^ stable_q);
      stable_d = stable_q ^ whack;
    end
  end

  always_comb begin
    hit_idx = '0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        hit_idx = IDX_W_C'(i);
      end
    end
    hit_valid   = |pending_q;
    hit_is_mole = hit_valid & hitmask_q[hit_idx];
    xfer        = hit_valid & hit_ready;
    drop_err    = drop_err_q;
  end

  // Clearing the transferred slot first lets a same-cycle re-whack of that switch land cleanly.
  always_comb begin
    pending_d  = pending_q;
    hitmask_d  = hitmask_q;
    drop_err_d = drop_err_q;
    if (xfer) begin
      pending_d[hit_idx] = 1'b0;
    end
    for (int i = 0; i < NUM_SW; i++) begin
      if (whack[i]) begin
        if (pending_d[i]) begin
          drop_err_d = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          hitmask_d[i] = mole_mask[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q  <= '0;
      hitmask_q  <= '0;
      drop_err_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      hitmask_q  <= hitmask_d;
      drop_err_q <= drop_err_d;
    end
  end

endmodule

// File: tb/tb_whack_input_conditioner.sv
// tb/tb_whack_input_conditioner.sv - randomized and directed bench against a behavioural event model
module tb_whack_input_conditioner;

  localparam int TICK = 4;
  localparam int N    = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sw = '0;
  logic [15:0] mole_mask = '0;
  logic        hit_ready = 1'b0;
  logic        hit_valid;
  logic [3:0]  hit_idx;
  logic        hit_is_mole;
  logic        drop_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  whack_input_conditioner #(
    .NUM_SW     (N),
    .TICK_CYCLES(TICK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .mole_mask  (mole_mask),
    .hit_ready  (hit_ready),
    .hit_valid  (hit_valid),
    .hit_idx    (hit_idx),
    .hit_is_mole(hit_is_mole),
    .drop_err   (drop_err)
  );

  // Reference model: per-switch bit arrays, edge count since release, raw sw history.
  logic [15:0] m_d1, m_d2;
  int          m_edges;
  bit          m_sample[N];
  bit          m_stable[N];
  bit          m_pend[N];
  bit          m_mole[N];
  bit          m_drop;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int m_lowest();
    for (int i = 0; i < N; i++) if (m_pend[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sample[i] = sw[i];
      m_stable[i] = sw[i];
      m_pend[i]   = 1'b0;
      m_mole[i]   = 1'b0;
    end
    m_drop  = 1'b0;
    m_d1    = sw;
    m_d2    = sw;
    m_edges = 0;
  endtask

  task automatic model_edge();
    int          lo;
    logic [15:0] synced;
    bit          nv;
    lo     = m_lowest();
    synced = m_d2;
    m_edges++;
    if (lo >= 0 && hit_ready) m_pend[lo] = 1'b0;
    if (m_edges % TICK == 0) begin
      for (int i = 0; i < N; i++) begin
        nv = synced[i];
        if (nv == m_sample[i] && nv != m_stable[i]) begin
          m_stable[i] = nv;
          if (m_pend[i]) m_drop = 1'b1;
          else begin
            m_pend[i] = 1'b1;
            m_mole[i] = mole_mask[i];
          end
        end
        m_sample[i] = nv;
      end
    end
    m_d2 = m_d1;
    m_d1 = sw;
  endtask

  task automatic compare();
    int lo;
    lo = m_lowest();
    chk("hit_valid", int'(hit_valid), int'(lo >= 0));
    if (lo >= 0) begin
      chk("hit_idx", int'(hit_idx), lo);
      chk("hit_is_mole", int'(hit_is_mole), int'(m_mole[lo]));
    end
    chk("drop_err", int'(drop_err), int'(m_drop));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  int cyc;
  int seen;
  int idx;

  initial begin
    // Reset state and quiet inputs
    sw = 16'h0000;
    hit_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_valid", int'(hit_valid), 0);
    chk("rst_idx", int'(hit_idx), 0);
    chk("rst_mole", int'(hit_is_mole), 0);
    chk("rst_drop", int'(drop_err), 0);
    do_reset();
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      hit_ready = $urandom_range(0, 1);
      step();
      if (hit_valid) seen++;
    end
    chk("quiet_no_event", seen, 0);

    // Single whack on a lit mole
    mole_mask = 16'h0020;
    hit_ready = 1'b1;
    sw[5] = 1'b1;
    cyc = 0;
    while (!hit_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("lat5_bound", int'(cyc <= 11), 1);
    chk("sw5_idx", int'(hit_idx), 5);
    chk("sw5_mole", int'(hit_is_mole), 1);
    step();
    chk("sw5_one_pulse", int'(hit_valid), 0);
    for (int k = 0; k < 10; k++) step();

    // Short glitch
    seen = 0;
    sw[3] = 1'b1;
    step();
    step();
    sw[3] = 1'b0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (hit_valid) seen++;
    end
    chk("glitch_none", seen, 0);

    // Two simultaneous events under backpressure
    hit_ready = 1'b0;
    sw[9] = ~sw[9];
    sw[2] = ~sw[2];
    for (int k = 0; k < 20; k++) step();
    chk("pair_first_idx", int'(hit_idx), 2);
    hit_ready = 1'b1;
    step();
    chk("pair_second_valid", int'(hit_valid), 1);
    chk("pair_second_idx", int'(hit_idx), 9);
    step();
    chk("pair_drained", int'(hit_valid), 0);
    for (int k = 0; k < 8; k++) step();

    // Toggle and toggle back while stalled: second event is dropped
    hit_ready = 1'b0;
    sw[7] = ~sw[7];
    for (int k = 0; k < 16; k++) step();
    sw[7] = ~sw[7];
    for (int k = 0; k < 16; k++) step();
    chk("drop_set", int'(drop_err), 1);
    hit_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (hit_valid && hit_ready) seen++;
      step();
    end
    chk("drop_one_delivered", seen, 1);

    // Reset in the middle of a stalled handshake
    hit_ready = 1'b0;
    sw[11] = ~sw[11];
    for (int k = 0; k < 16; k++) step();
    chk("pre_rst_valid", int'(hit_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", int'(hit_valid), 0);
    chk("async_rst_drop", int'(drop_err), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    hit_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (hit_valid) seen++;
    end
    chk("no_stale_event", seen, 0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        idx = $urandom_range(0, 15);
        sw[idx] = ~sw[idx];
      end else if (r < 7) begin
        idx = $urandom_range(0, 15);
        sw[idx] = ~sw[idx];
        step();
        sw[idx] = ~sw[idx];
      end
      if ($urandom_range(0, 15) == 0) mole_mask = 16'($urandom);
      if ($urandom_range(0, 7) == 0) hit_ready = ~hit_ready;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
